ddr2_rd_data_align: RTL

- Parametrised read-data aggregation and deskew stage; the next generation of the DDR2 read-data path.
- Takes per-lane calibrated read enables and first_rising flags from the per-lane pattern-compare instances.
- Buffers each lane's rise/fall words in a per-lane FIFO and releases a full-width word only when every lane holds data.
- Also aggregates the calibration status (comp_done, comp_error, cal_first_loop), and adds overflow and lane-skew detection that the fixed 4-lane path lacks.

---
 rtl/ddr2_rd_pkg.sv | 21 ++
 rtl/ddr2_rd_data_align_lane_fifo.sv | 87 ++++++++
 rtl/ddr2_rd_data_align.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ddr2_rd_pkg.sv
// Shared constants and helpers for the DDR2 read-data alignment path.
package ddr2_rd_pkg;

  localparam int DEF_NUM_LANES  = 4;
  localparam int DEF_LANE_WIDTH = 8;
  localparam int DATA_WIDTH     = DEF_NUM_LANES * DEF_LANE_WIDTH;

  // Lane FIFO entries are packed {fall, rise}: rise in the low slot.
  localparam int ENTRY_RISE_SLOT = 0;
  localparam int ENTRY_FALL_SLOT = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ddr2_rd_data_align_lane_fifo.sv
// Per-lane capture FIFO: optional rise-word hold for staggered lanes,
// circular buffer with wrap-bit pointers, sticky overflow.
module ddr2_rd_lane_fifo
  import ddr2_rd_pkg::*;
#(
  parameter int LANE_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    rd_en_rise,
  input  logic                    rd_en_fall,
  input  logic                    first_rising,
  input  logic [LANE_WIDTH-1:0]   data_rise,
  input  logic [LANE_WIDTH-1:0]   data_fall,
  input  logic                    pop,
  output logic [2*LANE_WIDTH-1:0] entry,
  output logic                    empty,
  output logic                    overflow
);

  localparam int AW = clog2(DEPTH);
  localparam int EW = 2 * LANE_WIDTH;

  logic [EW-1:0]         mem [0:DEPTH-1];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [LANE_WIDTH-1:0] held_rise;
  logic                  held_valid;
  logic                  full;
  logic                  wr_req;
  logic                  wr_ok;
  logic                  do_pop;
  logic [EW-1:0]         wr_entry;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop = pop & ~empty & ~flush;
  // A pop in the same cycle frees the slot, so a write to a full lane is still accepted.
  assign wr_ok  = wr_req & (~full | do_pop) & ~flush;
  assign entry  = mem[rd_ptr[AW-1:0]];

  always_comb begin
    wr_req   = 1'b0;
    wr_entry = '0;
    wr_entry[ENTRY_FALL_SLOT*LANE_WIDTH +: LANE_WIDTH] = data_fall;
    if (first_rising) begin
      wr_req = rd_en_fall & held_valid;
      wr_entry[ENTRY_RISE_SLOT*LANE_WIDTH +: LANE_WIDTH] = held_rise;
    end else begin
      wr_req = rd_en_rise;
      wr_entry[ENTRY_RISE_SLOT*LANE_WIDTH +: LANE_WIDTH] = data_rise;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      held_rise  <= '0;
      held_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (wr_req & full & ~do_pop & ~flush) overflow <= 1'b1;
      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        held_valid <= 1'b0;
      end else begin
        if (wr_ok)  wr_ptr <= wr_ptr + 1'b1;
        if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        if (first_rising & rd_en_rise) begin
          held_rise  <= data_rise;
          held_valid <= 1'b1;
        end else if (~first_rising | (rd_en_fall & held_valid)) begin
          held_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/ddr2_rd_data_align.sv
// Read-data deskew: releases one full-width word when every lane FIFO holds data,
// watches for lanes stuck partially filled, and aggregates calibration status.
module ddr2_rd_data_align
  import ddr2_rd_pkg::*;
#(
  parameter int NUM_LANES  = DEF_NUM_LANES,
  parameter int LANE_WIDTH = DEF_LANE_WIDTH,
  parameter int DEPTH      = 8,
  parameter int MAX_SKEW   = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            fifo_flush,
  input  logic [NUM_LANES-1:0]            lane_rd_en_rise,
  input  logic [NUM_LANES-1:0]            lane_rd_en_fall,
  input  logic [NUM_LANES-1:0]            lane_first_rising,
  input  logic [NUM_LANES-1:0]            lane_comp_done,
  input  logic [NUM_LANES-1:0]            lane_comp_error,
  input  logic [NUM_LANES-1:0]            lane_cal_first_loop,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] read_data_rise,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] read_data_fall,
  output logic                            read_data_valid,
  output logic [NUM_LANES*LANE_WIDTH-1:0] read_data_fifo_rise,
  output logic [NUM_LANES*LANE_WIDTH-1:0] read_data_fifo_fall,
  output logic                            comp_done,
  output logic                            comp_error,
  output logic                            cal_first_loop,
  output logic [NUM_LANES-1:0]            fifo_overflow,
  output logic                            skew_error
);

  localparam int DW = NUM_LANES * LANE_WIDTH;
  localparam int EW = 2 * LANE_WIDTH;

  logic [NUM_LANES-1:0] lane_empty;
  logic [EW-1:0]        lane_entry [NUM_LANES];
  logic [DW-1:0]        pop_rise;
  logic [DW-1:0]        pop_fall;
  logic                 pop;
  logic                 partial;
  logic                 skew_flush;
  logic                 flush_all;
  logic [7:0]           skew_cnt;
  logic [NUM_LANES-1:0] first_loop_r;
  logic [NUM_LANES-1:0] first_loop_prev;

  assign flush_all = fifo_flush | skew_flush;
  assign pop       = ~|lane_empty & ~flush_all;
  assign partial   = (|(~lane_empty)) & (|lane_empty);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    ddr2_rd_lane_fifo #(
      .LANE_WIDTH(LANE_WIDTH),
      .DEPTH     (DEPTH)
    ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush_all),
      .rd_en_rise  (lane_rd_en_rise[g]),
      .rd_en_fall  (lane_rd_en_fall[g]),
      .first_rising(lane_first_rising[g]),
      .data_rise   (read_data_rise[g*LANE_WIDTH +: LANE_WIDTH]),
      .data_fall   (read_data_fall[g*LANE_WIDTH +: LANE_WIDTH]),
      .pop         (pop),
      .entry       (lane_entry[g]),
      .empty       (lane_empty[g]),
      .overflow    (fifo_overflow[g])
    );
    assign pop_rise[g*LANE_WIDTH +: LANE_WIDTH] = lane_entry[g][ENTRY_RISE_SLOT*LANE_WIDTH +: LANE_WIDTH];
    assign pop_fall[g*LANE_WIDTH +: LANE_WIDTH] = lane_entry[g][ENTRY_FALL_SLOT*LANE_WIDTH +: LANE_WIDTH];
  end

  // Output handshake: read_data_valid is a one-cycle strobe per aligned word with
  // no backpressure; data outputs only change on a strobe and hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data_valid     <= 1'b0;
      read_data_fifo_rise <= '0;
      read_data_fifo_fall <= '0;
    end else begin
      read_data_valid <= pop;
      if (pop) begin
        read_data_fifo_rise <= pop_rise;
        read_data_fifo_fall <= pop_fall;
      end
    end
  end

  // Reaching MAX_SKEW partial cycles flags the error and flushes on the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skew_cnt   <= '0;
      skew_flush <= 1'b0;
      skew_error <= 1'b0;
    end else begin
      skew_flush <= 1'b0;
      if (flush_all || !partial) begin
        skew_cnt <= '0;
      end else if (skew_cnt == 8'(MAX_SKEW - 1)) begin
        skew_cnt   <= '0;
        skew_error <= 1'b1;
        skew_flush <= 1'b1;
      end else begin
        skew_cnt <= skew_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      comp_done       <= 1'b0;
      comp_error      <= 1'b0;
      first_loop_r    <= '1;
      first_loop_prev <= '1;
      cal_first_loop  <= 1'b1;
    end else begin
      comp_done       <= &lane_comp_done;
      comp_error      <= comp_error | (|lane_comp_error);
      first_loop_r    <= lane_cal_first_loop;
      first_loop_prev <= first_loop_r;
      cal_first_loop  <= !((first_loop_r != first_loop_prev) && !(&first_loop_r));
    end
  end

endmodule
